// File: rtl/cell_writer.sv
// cell_writer: bump-pointer heap allocator that serialises lisp cells onto a RAM write port
package lisp_pkg;
    localparam logic [7:0] NIL            = 8'h00;
    localparam logic [7:0] TYPE_NUMBER    = 8'h01;
    localparam logic [7:0] TYPE_CONS      = 8'h02;
    localparam logic [7:0] TYPE_FUNC_PRIM = 8'h03;
    localparam logic [7:0] TYPE_PRIM_ADD  = 8'h10;
endpackage

module cell_writer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] HEAP_BASE  = 'h20,
    parameter logic [ADDR_WIDTH-1:0] HEAP_LIMIT = 'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  heap_clear,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_kind,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  resp_valid,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic                  resp_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] free_ptr
);
    import lisp_pkg::*;

    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              kind_q, kind_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d, free_q, free_d;
    logic [2:0]              len_q, len_d;
    logic [1:0]              idx_q, idx_d;
    logic                    full_q, full_d;
    logic                    resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [ADDR_WIDTH-1:0]   resp_addr_q, resp_addr_d, mem_addr_q, mem_addr_d;
    logic                    mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    logic [2:0]              req_len;
    logic [ADDR_WIDTH:0]     end_addr, new_free;
    logic                    no_room, accept, last_byte;
    logic [1:0]              next_idx;
    logic [DATA_WIDTH-1:0]   req_tag, next_byte;

    assign req_ready = state_q == IDLE && !heap_clear && !rst;
    assign accept    = req_valid && req_ready;
    assign req_len   = req_kind == 2'd0 ? 3'd2 : req_kind == 2'd1 ? 3'd3 : 3'd4;
    assign req_tag   = req_kind == 2'd0 ? DATA_WIDTH'(TYPE_NUMBER) :
                       req_kind == 2'd1 ? DATA_WIDTH'(TYPE_CONS) : DATA_WIDTH'(TYPE_FUNC_PRIM);
    // full_q remembers a wrap past the top address so the heap stays closed until cleared
    assign end_addr  = {1'b0, free_q} + (ADDR_WIDTH+1)'(req_len) - (ADDR_WIDTH+1)'(1);
    assign no_room   = full_q || end_addr > {1'b0, HEAP_LIMIT};
    assign next_idx  = idx_q + 2'd1;
    assign last_byte = {1'b0, idx_q} + 3'd1 == len_q;
    assign new_free  = {1'b0, base_q} + (ADDR_WIDTH+1)'(len_q);
    assign next_byte = next_idx == 2'd1 ? a_q :
                       (next_idx == 2'd2 && kind_q == 2'd1) ? b_q : DATA_WIDTH'(NIL);

    // next-state and registered-output computation; mem_* carry the byte for the coming cycle
    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        a_d          = a_q;
        b_d          = b_q;
        base_d       = base_q;
        len_d        = len_q;
        idx_d        = idx_q;
        free_d       = free_q;
        full_d       = full_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_addr_d  = '0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (heap_clear) begin
                    free_d = HEAP_BASE;
                    full_d = 1'b0;
                end else if (accept) begin
                    kind_d = req_kind;
                    a_d    = req_a;
                    b_d    = req_b;
                    base_d = free_q;
                    len_d  = req_len;
                    idx_d  = 2'd0;
                    if (req_kind == 2'd3 || no_room) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = free_q;
                        mem_wdata_d = req_tag;
                    end
                end
            end
            WRITE: begin
                if (last_byte) begin
                    state_d      = RESP;
                    free_d       = new_free[ADDR_WIDTH-1:0];
                    full_d       = new_free[ADDR_WIDTH];
                    resp_valid_d = 1'b1;
                    resp_addr_d  = base_q;
                end else begin
                    idx_d       = next_idx;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base_q + ADDR_WIDTH'(next_idx);
                    mem_wdata_d = next_byte;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers; reset abandons any write in flight
    always_ff @(posedge clk) begin
        kind_d_reg: begin
            kind_q <= kind_d;
            a_q    <= a_d;
            b_q    <= b_d;
            base_q <= base_d;
            len_q  <= len_d;
            idx_q  <= idx_d;
        end
        if (rst) begin
            state_q      <= IDLE;
            free_q       <= HEAP_BASE;
            full_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_addr_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            free_q       <= free_d;
            full_q       <= full_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_addr_q  <= resp_addr_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_addr  = resp_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign free_ptr   = free_q;
endmodule

// File: tb/tb_cell_writer.sv
// tb_cell_writer: directed table-driven checks of cell_writer allocation, layout and corner cases
module tb_cell_writer;
    import lisp_pkg::*;

    logic       clk = 1'b0, rst = 1'b1, heap_clear = 1'b0, req_valid = 1'b0, sel = 1'b0;
    logic [1:0] req_kind = 2'd0;
    logic [7:0] req_a = 8'h00, req_b = 8'h00;
    logic       r1, rv1, re1, we1, r2, rv2, re2, we2;
    logic [7:0] ra1, ma1, md1, fp1, ra2, ma2, md2, fp2;
    logic       ready, rv, re, we;
    logic [7:0] ra, ma, md, fp;
    logic [7:0] mem [256];
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    cell_writer dut (
        .clk(clk), .rst(rst), .heap_clear(heap_clear & !sel), .req_valid(req_valid & !sel),
        .req_ready(r1), .req_kind(req_kind), .req_a(req_a), .req_b(req_b),
        .resp_valid(rv1), .resp_addr(ra1), .resp_err(re1),
        .mem_we(we1), .mem_addr(ma1), .mem_wdata(md1), .free_ptr(fp1)
    );

    cell_writer #(.HEAP_BASE(8'h21), .HEAP_LIMIT(8'h23)) dut_small (
        .clk(clk), .rst(rst), .heap_clear(heap_clear & sel), .req_valid(req_valid & sel),
        .req_ready(r2), .req_kind(req_kind), .req_a(req_a), .req_b(req_b),
        .resp_valid(rv2), .resp_addr(ra2), .resp_err(re2),
        .mem_we(we2), .mem_addr(ma2), .mem_wdata(md2), .free_ptr(fp2)
    );

    assign ready = sel ? r2 : r1;
    assign rv    = sel ? rv2 : rv1;
    assign re    = sel ? re2 : re1;
    assign we    = sel ? we2 : we1;
    assign ra    = sel ? ra2 : ra1;
    assign ma    = sel ? ma2 : ma1;
    assign md    = sel ? md2 : md1;
    assign fp    = sel ? fp2 : fp1;

    always @(negedge clk) if (we) mem[ma] = md;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic [1:0] k, input logic [7:0] a, input logic [7:0] b,
                          input logic clr, output logic [7:0] addr, output logic err,
                          output int nw, output int lat);
        int n;
        nw = 0; lat = 0; addr = 8'h00; err = 1'b0; n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin @(negedge clk); n++; end
        chk("ready_before_req", 32'(ready), 32'd1);
        req_kind = k; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        heap_clear = clr;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (we) nw++;
            if (rv) begin lat = i; addr = ra; err = re; break; end
        end
        heap_clear = 1'b0;
        if (lat == 0) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [1:0] k;
        logic [7:0] a, b, addr;
        logic       err;
        logic [7:0] fp;
        int         nw, lat;
    } vec_t;

    vec_t       v [4];
    logic [7:0] em1 [9];
    logic [7:0] em2 [17];
    logic [1:0] bk [6];
    logic [7:0] ba [6], bb [6], baddr [6];

    initial begin
        logic [7:0] addr;
        logic       err, busy_ok, seen;
        int         nw, lat, n;

        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        v[0] = '{2'd0, 8'h05, 8'h00, 8'h20, 1'b0, 8'h22, 2, 3};
        v[1] = '{2'd1, 8'h20, NIL, 8'h22, 1'b0, 8'h25, 3, 4};
        v[2] = '{2'd2, TYPE_PRIM_ADD, 8'h99, 8'h25, 1'b0, 8'h29, 4, 5};
        v[3] = '{2'd3, 8'h11, 8'h22, 8'h00, 1'b1, 8'h29, 0, 1};
        em1 = '{TYPE_NUMBER, 8'h05, TYPE_CONS, 8'h20, NIL, TYPE_FUNC_PRIM, TYPE_PRIM_ADD, NIL, NIL};
        bk = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1};
        ba = '{8'h05, 8'h03, TYPE_PRIM_ADD, 8'h22, 8'h20, 8'h24};
        bb = '{8'h00, 8'h00, 8'h00, NIL, 8'h28, 8'h2B};
        baddr = '{8'h20, 8'h22, 8'h24, 8'h28, 8'h2B, 8'h2E};
        em2 = '{TYPE_NUMBER, 8'h05, TYPE_NUMBER, 8'h03, TYPE_FUNC_PRIM, TYPE_PRIM_ADD, NIL, NIL,
                TYPE_CONS, 8'h22, NIL, TYPE_CONS, 8'h20, 8'h28, TYPE_CONS, 8'h24, 8'h2B};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_resp_valid", 32'(rv), 32'd0);
        chk("rst_resp_err", 32'(re), 32'd0);
        chk("rst_resp_addr", 32'(ra), 32'd0);
        chk("rst_mem_we", 32'(we), 32'd0);
        chk("rst_mem_addr", 32'(ma), 32'd0);
        chk("rst_mem_wdata", 32'(md), 32'd0);
        chk("rst_free_ptr", 32'(fp), 32'h20);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            do_req(v[i].k, v[i].a, v[i].b, 1'b0, addr, err, nw, lat);
            chk($sformatf("vec%0d_addr", i), 32'(addr), 32'(v[i].addr));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(v[i].err));
            chk($sformatf("vec%0d_writes", i), 32'(nw), 32'(v[i].nw));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(v[i].lat));
            chk($sformatf("vec%0d_free_ptr", i), 32'(fp), 32'(v[i].fp));
        end
        for (int i = 0; i < 9; i++) chk($sformatf("mem1_%0h", 8'h20 + i), 32'(mem[8'h20 + i]), 32'(em1[i]));

        @(negedge clk);
        heap_clear = 1'b1; req_valid = 1'b1; req_kind = 2'd0; req_a = 8'h44;
        #1 chk("clear_ready", 32'(ready), 32'd0);
        @(negedge clk);
        chk("clear_free_ptr", 32'(fp), 32'h20);
        chk("clear_no_write", 32'(we), 32'd0);
        heap_clear = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("clear_no_accept", 32'({we, rv}), 32'd0);

        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        req_kind = bk[0]; req_a = ba[0]; req_b = bb[0]; req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (!ready && n < 20) begin @(negedge clk); n++; end
            @(posedge clk);
            #1;
            if (i < 5) begin req_kind = bk[i+1]; req_a = ba[i+1]; req_b = bb[i+1]; end
            else req_valid = 1'b0;
            busy_ok = 1'b1; seen = 1'b0; addr = 8'h00;
            for (int j = 1; j <= 10; j++) begin
                @(negedge clk);
                if (ready) busy_ok = 1'b0;
                if (rv) begin seen = 1'b1; addr = ra; break; end
            end
            chk($sformatf("b2b%0d_resp", i), 32'(seen), 32'd1);
            chk($sformatf("b2b%0d_addr", i), 32'(addr), 32'(baddr[i]));
            chk($sformatf("b2b%0d_busy", i), 32'(busy_ok), 32'd1);
        end
        chk("b2b_free_ptr", 32'(fp), 32'h31);
        for (int i = 0; i < 17; i++) chk($sformatf("mem2_%0h", 8'h20 + i), 32'(mem[8'h20 + i]), 32'(em2[i]));

        do_req(2'd0, 8'h77, 8'h00, 1'b1, addr, err, nw, lat);
        chk("clr_in_write_addr", 32'(addr), 32'h31);
        chk("clr_in_write_free_ptr", 32'(fp), 32'h33);
        chk("clr_in_write_writes", 32'(nw), 32'd2);

        @(negedge clk);
        req_kind = 2'd2; req_a = TYPE_PRIM_ADD; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        nw = 0; n = 0;
        while (nw < 2 && n < 10) begin @(negedge clk); if (we) nw++; n++; end
        chk("rst_mid_bytes", 32'(nw), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_we", 32'(we), 32'd0);
        chk("rst_mid_free_ptr", 32'(fp), 32'h20);
        seen = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (rv || we) seen = 1'b1;
            @(negedge clk);
        end
        chk("rst_mid_no_resp", 32'(seen), 32'd0);

        sel = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        do_req(2'd1, 8'h21, NIL, 1'b0, addr, err, nw, lat);
        chk("fit_addr", 32'(addr), 32'h21);
        chk("fit_err", 32'(err), 32'd0);
        chk("fit_free_ptr", 32'(fp), 32'h24);
        chk("fit_writes", 32'(nw), 32'd3);
        do_req(2'd0, 8'h05, 8'h00, 1'b0, addr, err, nw, lat);
        chk("full_err", 32'(err), 32'd1);
        chk("full_addr", 32'(addr), 32'd0);
        chk("full_writes", 32'(nw), 32'd0);
        chk("full_latency", 32'(lat), 32'd1);
        chk("full_free_ptr", 32'(fp), 32'h24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
